// File: rtl/audio_voice_sequencer_if.sv
// Config write port and mixed-sample output of the voice sequencer.
// The master side drives ticks/writes; the slave side is the sequencer.
interface audio_voice_sequencer_if #(
    parameter int VOICES   = 4,
    parameter int BITDEPTH = 14
);
    localparam int VW      = $clog2(VOICES);
    localparam int MIXBITS = BITDEPTH + VW;

    logic               sample_tick;
    logic               reg_wr;
    logic [VW-1:0]      reg_addr;
    logic [31:0]        reg_wdata;
    logic [MIXBITS-1:0] sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output sample_tick, reg_wr, reg_addr, reg_wdata,
        input  sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, reg_wr, reg_addr, reg_wdata,
        output sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/audio_voice_sequencer.sv
// Time-multiplexed voice engine: one phase adder, waveform generator and gain
// stage shared by all voices, summed into one unsigned mixed sample per tick.
module audio_voice_sequencer #(
    parameter int VOICES      = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    audio_voice_sequencer_if.slave bus
);
    localparam int PW      = BITDEPTH + BITFRACTION;
    localparam int VW      = $clog2(VOICES);
    localparam int MIXBITS = BITDEPTH + VW;
    localparam logic [VW-1:0]       LAST = VW'(VOICES - 1);
    localparam logic [BITDEPTH-1:0] PWID = BITDEPTH'(2 ** (BITDEPTH - 4));

    typedef struct packed {
        logic        en;
        logic [3:0]  vol;
        logic [1:0]  wave;
        logic [15:0] inc;
    } cfg_t;

    typedef enum logic [2:0] {S_IDLE, S_PHASE, S_WAVE, S_SCALE, S_DONE} state_t;

    state_t state, state_nxt;

    cfg_t               shadow [VOICES];
    cfg_t               active [VOICES];
    logic [PW-1:0]      acc    [VOICES];
    logic [VOICES-1:0]  sub;
    logic [VW-1:0]      v;
    logic [BITDEPTH:0]  ph;       // pre-add phase: MSB plus the BITDEPTH bits below it
    logic               ph_sub;
    logic [BITDEPTH-1:0] wave;
    logic [MIXBITS-1:0] mix;
    logic [MIXBITS-1:0] sample_q;
    logic               valid_q;
    logic               overrun_q;

    cfg_t                cur;
    logic [PW:0]         sum;
    logic [BITDEPTH-1:0] top, tri_src, wave_nxt;
    logic                pulse;
    logic [4:0]          gain;
    logic [BITDEPTH+4:0] prod;
    logic [MIXBITS-1:0]  mix_nxt;

    always_comb begin
        cur      = active[v];
        sum      = {1'b0, acc[v]} + {{(PW + 1 - 16){1'b0}}, cur.inc};
        top      = ph[BITDEPTH:1];
        tri_src  = ph[BITDEPTH-1:0];
        pulse    = (top < PWID);
        wave_nxt = '0;
        if (cur.en) begin
            case (cur.wave)
                2'd0:    wave_nxt = top;
                2'd1:    wave_nxt = ph[BITDEPTH] ? ~tri_src : tri_src;
                2'd2:    wave_nxt = pulse ? '1 : '0;
                default: wave_nxt = (pulse == ph_sub) ? '1 : '0;
            endcase
        end
        gain    = {1'b0, cur.vol} + 5'd1;
        prod    = {5'b0, wave} * {{BITDEPTH{1'b0}}, gain};
        mix_nxt = mix + MIXBITS'(BITDEPTH'(prod >> 4));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.sample_tick) state_nxt = S_PHASE;
            S_PHASE: state_nxt = S_WAVE;
            S_WAVE:  state_nxt = S_SCALE;
            S_SCALE: state_nxt = (v == LAST) ? S_DONE : S_PHASE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                acc[i]    <= '0;
            end
            sub       <= '0;
            v         <= '0;
            ph        <= '0;
            ph_sub    <= 1'b0;
            wave      <= '0;
            mix       <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.sample_tick && state != S_IDLE) overrun_q <= 1'b1;
            if (bus.reg_wr) shadow[bus.reg_addr] <= cfg_t'(bus.reg_wdata[22:0]);
            case (state)
                S_IDLE: if (bus.sample_tick) begin
                    // old shadow value is copied; a same-cycle write lands next tick
                    active <= shadow;
                    mix    <= '0;
                    v      <= '0;
                end
                S_PHASE: begin
                    ph     <= acc[v][PW-1 -: BITDEPTH+1];
                    ph_sub <= sub[v];
                    if (cur.en) begin
                        acc[v] <= sum[PW-1:0];
                        if (sum[PW]) sub[v] <= ~sub[v];
                    end else begin
                        acc[v] <= '0;
                        sub[v] <= 1'b0;
                    end
                end
                S_WAVE: wave <= wave_nxt;
                S_SCALE: begin
                    mix <= mix_nxt;
                    v   <= v + 1'b1;
                    if (v == LAST) begin
                        sample_q <= mix_nxt;
                        valid_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_audio_voice_sequencer.sv
// Randomized + directed scoreboard bench for audio_voice_sequencer.
module tb_audio_voice_sequencer;
    localparam int VOICES = 4, BITDEPTH = 14, BITFRACTION = 6;
    localparam int LAT = 3 * VOICES + 1, GAP = 3 * VOICES + 2;
    localparam longint WRAP = 64'd1 << (BITDEPTH + BITFRACTION);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_voice_sequencer_if #(.VOICES(VOICES), .BITDEPTH(BITDEPTH)) bus();
    audio_voice_sequencer #(.VOICES(VOICES), .BITDEPTH(BITDEPTH), .BITFRACTION(BITFRACTION))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int at; } exp_t;
    exp_t q[$];

    logic [22:0] sh [VOICES];
    longint      m_acc [VOICES];
    int          m_sub [VOICES];
    int          last_acc;
    bit          m_ovr;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < VOICES; i++) begin
            sh[i] = '0; m_acc[i] = 0; m_sub[i] = 0;
        end
        last_acc = -1000;
        m_ovr    = 0;
        q.delete();
    endfunction

    // One whole output sample from the current settings, voice by voice.
    function automatic int model_sample();
        int mix, w, vol, top, mid;
        bit pulse;
        longint old, nx;
        logic [22:0] c;
        mix = 0;
        for (int i = 0; i < VOICES; i++) begin
            c = sh[i];
            vol = int'(c[21:18]);
            w = 0;
            if (c[22]) begin
                old = m_acc[i];
                top = int'(old / 64);
                pulse = (top < 1024);
                case (c[17:16])
                    2'd0: w = top;
                    2'd1: begin
                        mid = int'((old / 32) % 16384);
                        w = (old >= WRAP / 2) ? 16383 - mid : mid;
                    end
                    2'd2: w = pulse ? 16383 : 0;
                    default: w = (m_sub[i] == 1) ? (pulse ? 16383 : 0) : (pulse ? 0 : 16383);
                endcase
                nx = old + longint'(c[15:0]);
                if (nx >= WRAP) begin
                    nx -= WRAP;
                    m_sub[i] = 1 - m_sub[i];
                end
                m_acc[i] = nx;
            end else begin
                m_acc[i] = 0;
                m_sub[i] = 0;
            end
            mix += (w * (vol + 1)) / 16;
        end
        return mix;
    endfunction

    // One clock of stimulus, driven just after the rising edge.
    task automatic do_cycle(input bit tk, input bit wr, input int addr, input logic [31:0] data);
        exp_t e;
        @(posedge clk); #1;
        bus.sample_tick = tk;
        bus.reg_wr      = wr;
        bus.reg_addr    = addr[1:0];
        bus.reg_wdata   = data;
        if (tk) begin
            if (cyc - last_acc >= GAP) begin
                e.val = model_sample();
                e.at  = cyc + LAT;
                q.push_back(e);
                last_acc = cyc;
            end else m_ovr = 1;
        end
        if (wr) sh[addr] = data[22:0];
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            do_cycle(1, 0, 0, 0);
            idle(GAP - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.sample_tick = 0; bus.reg_wr = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        model_reset();
        @(posedge clk); @(negedge clk);
        chk("rst_sample_out", bus.sample_out, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] cfg(input int en, input int vol, input int wv, input int inc);
        logic [31:0] d;
        d = '0;
        d[22] = en[0]; d[21:18] = vol[3:0]; d[17:16] = wv[1:0]; d[15:0] = inc[15:0];
        return d;
    endfunction

    // Monitor: pops expected samples whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("busy", bus.busy, (cyc > last_acc && cyc <= last_acc + LAT) ? 1 : 0);
            if (bus.sample_valid) begin
                if (q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sample_out", bus.sample_out, e.val);
                    chk("valid_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        bus.sample_tick = 0; bus.reg_wr = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        model_reset();
        repeat (3) @(posedge clk);

        // idle voices produce silence
        do_reset();
        ticks(3);
        drain();
        chk("overrun_idle", bus.overrun, 0);

        // saw ramp on voice 0
        do_reset();
        do_cycle(0, 1, 0, cfg(1, 15, 0, 'h40));
        ticks(5);
        drain();

        // all voices pulse, through a full phase wrap
        do_reset();
        for (int i = 0; i < VOICES; i++) do_cycle(0, 1, i, cfg(1, 15, 2, 'h4000));
        ticks(66);
        drain();

        // sub-octave on voice 1, both polarities, then half volume
        do_reset();
        do_cycle(0, 1, 1, cfg(1, 15, 3, 'h4000));
        ticks(130);
        do_cycle(0, 1, 1, cfg(1, 7, 3, 'h4000));
        ticks(70);
        drain();

        // triangle, rate change while busy and in the same cycle as a tick
        do_reset();
        do_cycle(0, 1, 0, cfg(1, 15, 1, 'h1234));
        do_cycle(0, 1, 2, cfg(1, 3, 0, 'h0777));
        ticks(2);
        do_cycle(1, 0, 0, 0);
        idle(3);
        do_cycle(0, 1, 0, cfg(1, 15, 1, 'h2000));
        idle(GAP - 5);
        do_cycle(1, 1, 2, cfg(1, 15, 2, 'h3000));
        idle(GAP - 1);
        ticks(4);
        drain();

        // overrun: tick 5 cycles in, and tick in the final busy cycle
        do_reset();
        do_cycle(1, 0, 0, 0);
        idle(4);
        do_cycle(1, 0, 0, 0);
        drain();
        chk("overrun_set", bus.overrun, 1);
        do_cycle(1, 0, 0, 0);
        idle(GAP - 2);
        do_cycle(1, 0, 0, 0);
        ticks(2);
        drain();
        chk("overrun_sticky", bus.overrun, 1);

        // reset mid-sample aborts with no valid pulse
        do_cycle(0, 1, 0, cfg(1, 15, 2, 'h100));
        do_cycle(1, 0, 0, 0);
        idle(5);
        do_reset();
        idle(GAP + 4);
        chk("overrun_cleared", bus.overrun, 0);

        // randomized configs, writes and tick spacing
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 9);
            bit wr = (r < 4);
            bit tk = (cyc - last_acc >= GAP - 2) ? ($urandom_range(0, 3) != 0) : (r == 9);
            do_cycle(tk, wr, $urandom_range(0, VOICES - 1), $urandom);
        end
        idle(2);
        drain();
        chk("overrun_random", bus.overrun, m_ovr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/audio_voice_sequencer.md
Name: audio_voice_sequencer

Overview:
Time-multiplexed voice engine for the badge audio path. One shared phase adder, waveform generator and gain stage serve VOICES independent voices. On each sample tick the block steps through every voice with a small FSM and sums their outputs into one mixed sample. Software configures it through a simple register write port, and the mixed sample feeds the audio DAC/PDM stage.

Parameters:
VOICES, 4, number of voices; must be a power of two, 2..8.
BITDEPTH, 14, waveform width per voice.
BITFRACTION, 6, fractional phase bits; phase accumulator width is BITDEPTH+BITFRACTION (PW).
MIXBITS, BITDEPTH+log2(VOICES), mixed output width (derived; not overridable).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_tick  in  1  one-cycle pulse requesting one output sample
reg_wr  in  1  config write strobe
reg_addr  in  log2(VOICES)  voice index for the write
reg_wdata  in  32  [15:0] increment, [17:16] waveform (0 SAW, 1 TRI, 2 PULSE, 3 SUB), [21:18] volume, [22] enable
sample_out  out  MIXBITS  last completed mixed sample, unsigned
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high while a sample is being computed
overrun  out  1  sticky; set when a tick arrives while busy

Behaviour:
- Reset (synchronous, active-high): all shadow and active config = 0 (voices disabled); accumulators = 0; sub flags = 0; sample_out = 0; sample_valid = 0; busy = 0; overrun = 0; FSM = IDLE. A reset mid-sample aborts the sample with no valid pulse.
- Config: reg_wr writes the shadow register of voice reg_addr in the same cycle. Shadow registers are copied to the active set only when a tick is accepted, so a sample never mixes old and new settings. A write in the same cycle as an accepted tick is not copied; it takes effect on the next tick.
- FSM per voice v (v = 0..VOICES-1): PHASE -> WAVE -> SCALE, then next v. After the last voice: DONE -> IDLE.
- IDLE: on sample_tick, copy shadow to active, mix = 0, v = 0, busy = 1, go to PHASE.
- PHASE: wave input = accumulator[v] value before the add. If enabled: acc[v] <= acc[v] + increment (mod 2^PW), and on carry-out sub[v] toggles. If disabled: acc[v] <= 0, sub[v] <= 0.
- WAVE, with top = old acc[PW-1 -: BITDEPTH] and PWID = 2^(BITDEPTH-4):
  - SAW: top.
  - TRI: acc MSB ? ~acc[PW-2 -: BITDEPTH] : acc[PW-2 -: BITDEPTH].
  - PULSE: top < PWID ? 2^BITDEPTH-1 : 0.
  - SUB: PULSE level when sub = 1, its inverse when sub = 0.
  - Disabled voice: 0.
- SCALE: mix += (wave * (volume+1)) >> 4. Volume 15 is unity gain; volume 0 is 1/16. Arithmetic is unsigned and never overflows MIXBITS.
- DONE: sample_out <= mix; sample_valid = 1 for exactly this cycle; busy <= 0.
- Latency: tick accepted at cycle T gives sample_valid at T+3*VOICES+1. Ticks must be spaced at least 3*VOICES+2 cycles apart.
- Tick while busy (including the DONE cycle): tick is dropped, overrun <= 1, and the sample in progress continues unaffected. overrun clears only on rst.
- Accumulator wrap is modulo 2^PW. Increment 0 holds phase.

Test Plan:
- Reset then 3 ticks, no writes -> sample_out = 0 on each valid; valid arrives 13 cycles after each tick (VOICES = 4); overrun = 0.
- Voice 0: SAW, increment 0x0040, volume 15, enable; 5 ticks -> sample_out = 0, 1, 2, 3, 4.
- All 4 voices: PULSE, increment 0x4000, volume 15 -> samples 1-4 = 65532, samples 5-64 = 0, sample 65 = 65532 (wrap).
- Voice 1: SUB, increment 0x4000 -> samples 1-4 = 0, samples 5-64 = 16383, then inverted polarity for the next 64 samples; volume 7 halves each level (16383 -> 8191).
- Write voice 0 increment while busy -> the current and next sample keep the old rate; the change applies from the tick after the write.
- Second tick 5 cycles after the first -> overrun = 1, exactly one sample_valid; overrun stays set until rst; rst mid-sample -> no valid pulse and all outputs return to 0.
